// File: rtl/cool_heat_pwm_controller.sv
// cool_heat_pwm_controller
//
// Hysteresis thermostat with a fan PWM, driven by an external free-running
// 8-bit period counter. A "boundary" is any posedge clk where cnt_value is
// 8'hFF. The temperature is sampled only at a boundary. State, enables, fan
// level and PWM duty change only there, so a PWM period is never cut short
// by a duty change.
//
// Ports:
//   clk          clock, rising edge
//   arst         asynchronous active-high reset
//   cnt_value    free-running period counter (0..255, wraps)
//   temperature  unsigned degrees C
//   heater_on    registered, high while state is HEATING
//   cooler_on    registered, high while state is COOLING
//   fan_level    registered fan speed 0..3
//   pwm_out      registered fan PWM, high for duty clocks out of every 256
//   state        00 IDLE, 01 HEATING, 10 COOLING
//   alarm        sticky overheat flag
//
// Build option: define COOL_HEAT_ALARM_EN to build the overheat alarm.
// Without it, alarm is tied low and ALARM_TEMP does not exist.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | temperature inside the comfort band, no heat, no cooling
// HEAT  | heater on, fan at level 1
// COOL  | cooler on, fan level 1..3 from how far above COOL_ON
module cool_heat_pwm_controller #(
  parameter logic [7:0] HEAT_ON    = 8'd15,
  parameter logic [7:0] HEAT_OFF   = 8'd20,
  parameter logic [7:0] COOL_OFF   = 8'd25,
`ifdef COOL_HEAT_ALARM_EN
  parameter logic [7:0] COOL_ON    = 8'd35,
  parameter logic [7:0] ALARM_TEMP = 8'd60
`else
  parameter logic [7:0] COOL_ON    = 8'd35
`endif
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] cnt_value,
  input  logic [7:0] temperature,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [1:0] fan_level,
  output logic       pwm_out,
  output logic [1:0] state,
  output logic       alarm
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HEAT = 2'b01;
  localparam logic [1:0] ST_COOL = 2'b10;

  logic       boundary;
  logic [1:0] next_state;
  logic [1:0] next_level;
  logic [7:0] duty_reg;
  logic [8:0] temp9;
  logic [8:0] lvl2_th;
  logic [8:0] lvl3_th;

  assign boundary = (cnt_value == 8'hFF);

  // Widened so COOL_ON near 255 cannot wrap the level thresholds.
  assign temp9   = {1'b0, temperature};
  assign lvl2_th = {1'b0, COOL_ON} + 9'd5;
  assign lvl3_th = {1'b0, COOL_ON} + 9'd15;

`ifdef COOL_HEAT_ALARM_EN
  logic next_alarm;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (temperature < HEAT_ON)      next_state = ST_HEAT;
        else if (temperature > COOL_ON) next_state = ST_COOL;
      end
      ST_HEAT: if (temperature >= HEAT_OFF) next_state = ST_IDLE;
      ST_COOL: if (temperature <= COOL_OFF) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase

    next_level = 2'd0;
    case (next_state)
      ST_HEAT: next_level = 2'd1;
      ST_COOL: begin
        if (temp9 >= lvl3_th)      next_level = 2'd3;
        else if (temp9 >= lvl2_th) next_level = 2'd2;
        else                       next_level = 2'd1;
      end
      default: next_level = 2'd0;
    endcase

`ifdef COOL_HEAT_ALARM_EN
    // Overheat overrides the FSM from any state. Once raised, the alarm
    // holds the fan at full speed until COOLING falls back to IDLE; while
    // alarm is set the state is always COOLING, so the normal FSM decides
    // the exit.
    next_alarm = alarm;
    if (temperature >= ALARM_TEMP) begin
      next_state = ST_COOL;
      next_level = 2'd3;
      next_alarm = 1'b1;
    end else if (alarm) begin
      if (next_state == ST_COOL) next_level = 2'd3;
      else                       next_alarm = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= ST_IDLE;
      heater_on <= 1'b0;
      cooler_on <= 1'b0;
      fan_level <= 2'd0;
      duty_reg  <= 8'd0;
      pwm_out   <= 1'b0;
    end else begin
      // Compares against the pre-update duty; at a boundary cnt_value is 255
      // so the period always ends low and the new duty starts at count 0.
      pwm_out <= (cnt_value < duty_reg);
      if (boundary) begin
        state     <= next_state;
        heater_on <= (next_state == ST_HEAT);
        cooler_on <= (next_state == ST_COOL);
        fan_level <= next_level;
        duty_reg  <= {next_level, 6'b0};
      end
    end
  end

`ifdef COOL_HEAT_ALARM_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst)          alarm <= 1'b0;
    else if (boundary) alarm <= next_alarm;
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: doc/cool_heat_pwm_controller.md
Name: cool_heat_pwm_controller

Overview:
Downstream consumer of the cool/heat system's free-running 8-bit counter. Runs a hysteresis FSM (IDLE/HEATING/COOLING) on the room temperature and drives heater/cooler enables. Generates a fan PWM whose 256-cycle period is set by the counter value. Decisions and duty changes take effect only at period boundaries, so the PWM never glitches mid-period.

Parameters:
HEAT_ON, 8'd15, enter HEATING when temp < HEAT_ON
HEAT_OFF, 8'd20, leave HEATING when temp >= HEAT_OFF
COOL_OFF, 8'd25, leave COOLING when temp <= COOL_OFF
COOL_ON, 8'd35, enter COOLING when temp > COOL_ON
ALARM_TEMP, 8'd60, overheat threshold (optional feature only)
Legal only if HEAT_ON < HEAT_OFF < COOL_OFF < COOL_ON; otherwise behaviour is undefined.

Ports:
clk  in  1  clock, posedge
arst  in  1  reset, asynchronous, active-high
cnt_value  in  8  free-running period counter, increments by 1 per clk and wraps 255->0
temperature  in  8  unsigned degrees C
heater_on  out  1  registered; 1 iff state == HEATING
cooler_on  out  1  registered; 1 iff state == COOLING
fan_level  out  2  registered fan speed, 0..3
pwm_out  out  1  registered fan PWM
state  out  2  00 IDLE, 01 HEATING, 10 COOLING; 11 never produced
alarm  out  1  overheat flag; constant 0 when the optional feature is off

Behaviour:
- Reset: arst=1 clears state, heater_on, cooler_on, fan_level, internal duty_reg, pwm_out and alarm to 0 immediately, without waiting for a clock edge. Reset mid-period aborts the period. After release, the first decision happens at the next boundary.
- Boundary: any posedge where cnt_value == 8'hFF. Temperature is sampled only at a boundary. State, fan_level, heater_on, cooler_on and duty_reg update at that same edge. Temperature changes between boundaries are ignored.
- FSM transitions, evaluated at boundary only:
  - IDLE: temp < HEAT_ON -> HEATING. Else temp > COOL_ON -> COOLING. Else stay in IDLE.
  - HEATING: temp >= HEAT_OFF -> IDLE. Else stay.
  - COOLING: temp <= COOL_OFF -> IDLE. Else stay.
  - No direct HEATING<->COOLING transition.
- fan_level is computed at the boundary from the next state and the sampled temp:
  - IDLE -> 0.
  - HEATING -> 1.
  - COOLING -> 3 if temp >= COOL_ON+15; 2 if temp >= COOL_ON+5; otherwise 1.
  - These sums are computed 9 bits wide; no wrap.
- duty_reg = {fan_level_next, 6'b0}, giving duty values 0, 64, 128, 192.
- PWM: every posedge, pwm_out <= (cnt_value < duty_reg), using the pre-update duty_reg.
  - At a boundary cnt_value = 255, so pwm_out <= 0 in every case.
  - From the edge sampling cnt_value = 0, the new duty applies.
  - Result: pwm_out is high for exactly duty_reg clocks per 256, delayed one clock from the counter.
- Single clock domain; no handshake. Counter continuity is the caller's responsibility. If the counter skips 255, no boundary occurs and all outputs except pwm_out hold.

Optional Feature:
COOL_HEAT_ALARM_EN
- Defined: at a boundary, temp >= ALARM_TEMP forces state = COOLING, fan_level = 3 and alarm = 1, from any state.
  - alarm is sticky; it clears only at a boundary where COOLING exits to IDLE (temp <= COOL_OFF), or on reset.
  - While alarm = 1, fan_level stays 3 regardless of temp.
- Undefined: alarm is tied to 0 and no alarm logic is built. Temp >= ALARM_TEMP is handled by the normal FSM only.

Test Plan:
1. Counter running, temp=10, first boundary -> state=01, heater_on=1, fan_level=1; pwm_out high for exactly 64 clocks per 256-clock period from the following period on.
2. In HEATING, temp=19 at boundary -> stays HEATING. Temp=20 at next boundary -> IDLE, all outputs 0, pwm low through the whole next period.
3. IDLE, temp=36 -> COOLING, level 1 (64 high). Temp=41 -> level 2 (128). Temp=50 -> level 3 (192). Temp changed to 50 at cnt=100 -> no change until cnt=255.
4. IDLE, temp=30 -> stays IDLE. COOLING, temp=26 -> stays COOLING. Temp=25 -> IDLE at that boundary.
5. State COOLING level 3, assert arst at cnt=120 between edges -> all outputs 0 before the next posedge. Release at cnt=130 -> no change until cnt=255.
6. With COOL_HEAT_ALARM_EN defined: from HEATING, temp=60 -> state=10, alarm=1, level 3. Temp=30 -> alarm stays 1, level 3. Temp=25 -> IDLE, alarm=0. Without the macro, the same stimulus keeps alarm=0 and follows the normal FSM.
